// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues in-order imem requests, pairs responses with their PC
// and buffers them for decode; a redirect flushes the buffer and drops in-flight responses.
//
// state | meaning
// BOOT  | one idle cycle after reset release, no requests
// FETCH | normal operation, left only through reset
module fetch_stage #(
    parameter int unsigned         AddrSize  = 32,
    parameter int unsigned         InstrSize = 32,
    parameter logic [AddrSize-1:0] ResetPc   = '0,
    parameter int unsigned         Depth     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    output logic [AddrSize-1:0]  imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [InstrSize-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [AddrSize-1:0]  redirect_pc_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [InstrSize-1:0] instruction_o,
    output logic [AddrSize-1:0]  pc_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);
    localparam logic [CntW:0]   DepthL = (CntW + 1)'(Depth);

    typedef enum logic {BOOT, FETCH} state_t;
    state_t state, state_next;

    logic [AddrSize-1:0]  pc;
    logic [AddrSize-1:0]  fifo_pc    [Depth];
    logic [InstrSize-1:0] fifo_instr [Depth];
    logic [PtrW-1:0]      fifo_wr, fifo_rd;
    logic [CntW-1:0]      fifo_count;
    logic [AddrSize-1:0]  flight_pc  [Depth];
    logic [PtrW-1:0]      flight_wr, flight_rd;
    logic [CntW-1:0]      outstanding, drop;

    logic [CntW:0]        live;
    logic [CntW-1:0]      outstanding_upd;
    logic                 grant, resp, redir, push, pop;
    logic                 unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc_i[1:0];

    // Requests not yet discarded and not yet consumed by decode must fit the FIFO;
    // the in-flight PC queue additionally bounds raw outstanding requests.
    assign live = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, drop};

    always_comb begin
        state_next = state;
        imem_req_o = 1'b0;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   imem_req_o = (live < DepthL) && (outstanding < DepthC);
            default: state_next = BOOT;
        endcase
    end

    assign grant = imem_req_o & imem_gnt_i;
    assign resp  = imem_rvalid_i && (outstanding != '0);
    assign redir = redirect_i && (state == FETCH);
    assign push  = resp && (drop == '0) && !redir;
    assign pop   = valid_o && ready_i && !redir;
    assign outstanding_upd = outstanding + CntW'(grant) - CntW'(resp);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= BOOT;
            pc          <= ResetPc;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            fifo_count  <= '0;
            flight_wr   <= '0;
            flight_rd   <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_upd;
            if (grant) flight_wr <= flight_wr + 1'b1;
            if (resp)  flight_rd <= flight_rd + 1'b1;

            if (redir) begin
                pc         <= {redirect_pc_i[AddrSize-1:2], 2'b00};
                drop       <= outstanding_upd;
                fifo_rd    <= fifo_wr;
                fifo_count <= '0;
            end else begin
                if (grant)                  pc   <= pc + AddrSize'(4);
                if (resp && (drop != '0))   drop <= drop - 1'b1;
                if (push)                   fifo_wr <= fifo_wr + 1'b1;
                if (pop)                    fifo_rd <= fifo_rd + 1'b1;
                fifo_count <= fifo_count + CntW'(push) - CntW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) flight_pc[flight_wr] <= pc;
        if (push) begin
            fifo_pc[fifo_wr]    <= flight_pc[flight_rd];
            fifo_instr[fifo_wr] <= imem_rdata_i;
        end
    end

    assign imem_addr_o   = pc;
    assign valid_o       = (fifo_count != '0);
    assign instruction_o = valid_o ? fifo_instr[fifo_rd] : '0;
    assign pc_o          = valid_o ? fifo_pc[fifo_rd] : '0;

    // A response with nothing outstanding is a memory protocol error and is ignored.
    assert property (@(posedge clk_i) disable iff (!rst_i) imem_rvalid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (epoch-tagged in-flight list and an output queue).
module tb_fetch_stage;
    localparam int Depth = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid, redirect, valid, ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, pc;

    always #5 clk = ~clk;

    fetch_stage #(.AddrSize(32), .InstrSize(32), .ResetPc(32'h0), .Depth(Depth)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .valid_o(valid), .ready_i(ready),
        .instruction_o(instruction), .pc_o(pc)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] epoch;
    } flight_t;

    flight_t     pend[$];
    logic [63:0] outq[$];
    logic [31:0] fetch_pc;
    logic [31:0] epoch;
    logic        booted;
    int          grants;
    int          passed = 0;
    int          total = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1357_2468;
    endfunction

    function automatic logic model_req();
        int live;
        live = outq.size();
        foreach (pend[i]) if (pend[i].epoch == epoch) live++;
        return booted && (live < Depth) && (pend.size() < Depth);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   imem_req,    32'h0);
        check({tag, "_addr"},  imem_addr,   32'h0);
        check({tag, "_valid"}, valid,       32'h0);
        check({tag, "_instr"}, instruction, 32'h0);
        check({tag, "_pc"},    pc,          32'h0);
    endtask

    // Entered at a falling edge; asserts reset asynchronously between edges.
    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; ready = 0;
        #1 check_reset_outputs(tag);
        pend.delete(); outq.delete();
        fetch_pc = 32'h0; epoch = 0; booted = 0; grants = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive, check all outputs against the model, advance the model.
    task automatic step(input logic g, input logic rv, input logic rdy,
                        input logic rd, input logic [31:0] rpc);
        logic    exp_req, rv_now, grant;
        flight_t f;
        rv_now      = rv && (pend.size() > 0);
        imem_gnt    = g;
        ready       = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = rv_now;
        imem_rdata  = rv_now ? mem(pend[0].addr) : $urandom;
        exp_req     = model_req();
        #1;
        check("req",   imem_req,  exp_req);
        check("addr",  imem_addr, fetch_pc);
        check("valid", valid,     outq.size() > 0);
        if (outq.size() > 0) begin
            check("pc",    pc,          outq[0][63:32]);
            check("instr", instruction, outq[0][31:0]);
        end
        grant = exp_req && g;
        if (outq.size() > 0 && rdy && !rd) void'(outq.pop_front());
        if (rv_now) begin
            f = pend.pop_front();
            if (f.epoch == epoch && !rd) outq.push_back({f.addr, mem(f.addr)});
        end
        if (grant) begin
            pend.push_back('{addr: fetch_pc, epoch: epoch});
            fetch_pc = fetch_pc + 32'd4;
            grants++;
        end
        if (rd) begin
            outq.delete();
            epoch    = epoch + 1;
            fetch_pc = {rpc[31:2], 2'b00};
        end
        booted = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; ready = 0;
        @(negedge clk);
        do_reset("rst0");

        // Streaming with always-grant, single-cycle responses, decode always ready
        repeat (12) step(1, 1, 1, 0, 0);

        // Decode stalled: FIFO fills after two grants and requests stop
        do_reset("rst1");
        repeat (6) step(1, 1, 0, 0, 0);
        check("stall_grants", grants, 2);
        check("stall_req", imem_req, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        check("unstall_grants", grants, 3);
        repeat (4) step(1, 1, 1, 0, 0);

        // Grant withheld: PC holds
        do_reset("rst2");
        repeat (4) step(0, 1, 1, 0, 0);
        check("nogrant_addr", imem_addr, 32'h0);
        repeat (3) step(1, 1, 1, 0, 0);

        // Redirect with two requests in flight, unaligned target
        do_reset("rst3");
        repeat (3) step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 32'h103);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_valid", valid, 0);
        repeat (8) step(1, 1, 1, 0, 0);

        // Redirect coinciding with a grant and a pop
        for (int i = 0; i < 6 && !(imem_req && valid); i++) step(1, 1, 1, 0, 0);
        check("combo_req", imem_req, 1);
        check("combo_valid", valid, 1);
        step(1, 1, 1, 1, 32'h2000);
        check("combo_addr", imem_addr, 32'h2000);
        check("combo_valid_after", valid, 0);
        repeat (8) step(1, 1, 1, 0, 0);

        // PC wrap at the top of the address space
        step(1, 1, 1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 6 && imem_addr === 32'hFFFF_FFFC; i++) step(1, 1, 1, 0, 0);
        check("wrap_addr", imem_addr, 32'h0);
        repeat (6) step(1, 1, 1, 0, 0);

        // Asynchronous reset mid-stream, then random traffic
        do_reset("rst4");
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, booted && ($urandom_range(0, 24) == 0), $urandom);
            if (i == 1500) do_reset("rst5");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
